// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizes for the SRAM initiator and the SRAM it talks to.
package sram_ctrl_pkg;

  localparam int SRAM_ADDR_W = 11;
  localparam int SRAM_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    RD_LO = 3'd1,
    RD_HI = 3'd2,
    WR_LO = 3'd3,
    WR_HI = 3'd4,
    DONE  = 3'd5
  } sram_ctrl_state_t;

endpackage

// File: rtl/sram_ctrl_if.sv
// CPU-side request/response bundle between the memory stage and sram_ctrl.
interface sram_ctrl_if
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
);

  logic                  req;
  logic                  wr;
  logic                  half;
  logic [ADDR_W-1:0]     cpu_addr;
  logic [2*DATA_W-1:0]   wdata;
  logic [2*DATA_W-1:0]   rdata;
  logic                  busy;
  logic                  done;

  modport master (
    output req, wr, half, cpu_addr, wdata,
    input  rdata, busy, done
  );

  modport slave (
    input  req, wr, half, cpu_addr, wdata,
    output rdata, busy, done
  );

endinterface

// File: rtl/sram_ctrl.sv
// Turns one CPU load/store into one (halfword) or two (word) SRAM bus cycles.
// Word layout: low half at the even address, high half at the following odd one.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int ADDR_W = SRAM_ADDR_W,
  parameter int DATA_W = SRAM_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  sram_ctrl_if.slave        cpu,
  output logic [ADDR_W-1:0] address,
  inout  wire  [DATA_W-1:0] data,
  output logic              we,
  output logic              re
);

  sram_ctrl_state_t    state;
  logic                half_q;
  logic [ADDR_W-1:0]   base_q;
  logic [2*DATA_W-1:0] wdata_q;
  logic [2*DATA_W-1:0] rdata_q;
  logic                busy_q;
  logic                done_q;

  logic [ADDR_W-1:0]   accept_addr;
  logic [ADDR_W-1:0]   hi_addr;
  logic [DATA_W-1:0]   drive_val;

  // Word accesses start on the even halfword; halfwords use the exact address.
  assign accept_addr = cpu.half ? cpu.cpu_addr : {cpu.cpu_addr[ADDR_W-1:1], 1'b0};
  assign hi_addr     = {base_q[ADDR_W-1:1], 1'b1};

  // Which latched store half goes on the bus follows the registered state.
  assign drive_val = (state == WR_HI) ? wdata_q[2*DATA_W-1:DATA_W] : wdata_q[DATA_W-1:0];

  // The bus is only driven while we is high, otherwise it is released.
  assign data = we ? drive_val : {DATA_W{1'bz}};

  assign cpu.rdata = rdata_q;
  assign cpu.busy  = busy_q;
  assign cpu.done  = done_q;

  // Transaction FSM; every bus and status output is registered alongside the state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      half_q  <= 1'b0;
      base_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we      <= 1'b0;
      re      <= 1'b0;
      address <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu.req) begin
            half_q  <= cpu.half;
            base_q  <= accept_addr;
            wdata_q <= cpu.wdata;
            address <= accept_addr;
            busy_q  <= 1'b1;
            if (cpu.wr) begin
              state <= WR_LO;
              we    <= 1'b1;
            end else begin
              state <= RD_LO;
              re    <= 1'b1;
            end
          end
        end
        RD_LO: begin
          rdata_q[DATA_W-1:0] <= data;
          if (half_q) begin
            rdata_q[2*DATA_W-1:DATA_W] <= '0;
            state   <= DONE;
            done_q  <= 1'b1;
            re      <= 1'b0;
            address <= '0;
          end else begin
            state   <= RD_HI;
            address <= hi_addr;
          end
        end
        RD_HI: begin
          rdata_q[2*DATA_W-1:DATA_W] <= data;
          state   <= DONE;
          done_q  <= 1'b1;
          re      <= 1'b0;
          address <= '0;
        end
        WR_LO: begin
          if (half_q) begin
            state   <= DONE;
            done_q  <= 1'b1;
            we      <= 1'b0;
            address <= '0;
          end else begin
            state   <= WR_HI;
            address <= hi_addr;
          end
        end
        WR_HI: begin
          state   <= DONE;
          done_q  <= 1'b1;
          we      <= 1'b0;
          address <= '0;
        end
        DONE: begin
          state  <= IDLE;
          done_q <= 1'b0;
          busy_q <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          we      <= 1'b0;
          re      <= 1'b0;
          address <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl with a behavioural SRAM and a cycle-level bus model.
module tb_sram_ctrl
  import sram_ctrl_pkg::*;
;

  logic        clk;
  logic        reset;
  logic [10:0] address;
  wire  [15:0] data;
  logic        we;
  logic        re;

  sram_ctrl_if bus ();

  sram_ctrl dut (
    .clk     (clk),
    .reset   (reset),
    .cpu     (bus.slave),
    .address (address),
    .data    (data),
    .we      (we),
    .re      (re)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Free-running clock, 10 time units per cycle.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural SRAM: mem[i] starts as 16'h5A00 ^ i; writes commit on the rising edge when we=1.
  logic [15:0] mem [0:2047];
  logic        mem_ready = 1'b0;
  logic [15:0] idle_pat;

  always @(posedge clk) begin
    if (reset && !mem_ready) begin
      for (int i = 0; i < 2048; i++) mem[i] <= 16'h5A00 ^ 16'(i);
      mem_ready <= 1'b1;
      idle_pat  <= 16'hA5C3;
    end else begin
      if (we) mem[address] <= data;
      idle_pat <= ~idle_pat;
    end
  end

  // When the controller is not writing, the bench owns the bus: read data or a toggling pattern.
  assign data = we ? 16'bz : (re ? mem[address] : idle_pat);

  // Independent timing model: cycles left in the current transaction plus latched request fields.
  int          m_rem = 0;
  logic        m_wr;
  logic        m_half;
  logic [10:0] m_base;
  int          accepted_cnt = 0;
  int          done_cnt = 0;
  logic        m_lo;
  logic        m_hi;
  logic [10:0] m_addr;
  logic        mon_en;

  always @(posedge clk) begin
    if (reset) begin
      m_rem <= 0;
    end else if (m_rem == 0 && bus.req) begin
      m_rem        <= bus.half ? 2 : 3;
      m_wr         <= bus.wr;
      m_half       <= bus.half;
      m_base       <= bus.half ? bus.cpu_addr : {bus.cpu_addr[10:1], 1'b0};
      accepted_cnt <= accepted_cnt + 1;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
    end
  end

  assign m_lo   = m_half ? (m_rem == 2) : (m_rem == 3);
  assign m_hi   = !m_half && (m_rem == 2);
  assign m_addr = m_lo ? m_base : (m_hi ? {m_base[10:1], 1'b1} : 11'd0);

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    n_assert++;
    assert (observed === expected) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Every cycle: bus exclusivity, release of data, and timing against the model.
  always @(negedge clk) begin
    if (mon_en) begin
      checkOutput("re_we_exclusive", {63'd0, re & we}, 64'd0);
      checkOutput("busy_model", bus.busy, m_rem != 0);
      checkOutput("done_model", bus.done, m_rem == 1);
      checkOutput("address_model", address, m_addr);
      checkOutput("re_model", re, !m_wr && (m_lo || m_hi));
      checkOutput("we_model", we, m_wr && (m_lo || m_hi));
      if (!we) checkOutput("data_released", data, re ? mem[m_addr] : idle_pat);
      if (bus.done) done_cnt <= done_cnt + 1;
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic applyStimulus(input logic r, input logic w, input logic h,
                               input logic [10:0] a, input logic [31:0] wd);
    bus.req      = r;
    bus.wr       = w;
    bus.half     = h;
    bus.cpu_addr = a;
    bus.wdata    = wd;
  endtask

  // One request pulse; returns cycles from acceptance to done and rdata seen with done.
  task automatic doTxn(input logic w, input logic h, input logic [10:0] a,
                       input logic [31:0] wd, output int lat, output logic [31:0] rd);
    applyStimulus(1'b1, w, h, a, wd);
    tick();
    applyStimulus(1'b0, w, h, a, wd);
    lat = 1;
    while (!bus.done && lat < 10) begin
      tick();
      lat++;
    end
    rd = bus.rdata;
    tick();
  endtask

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat;
    logic [31:0] rd;
    int          acc0;
    int          done0;
    logic        rw;
    logic        rh;

    mon_en = 1'b0;
    reset  = 1'b1;
    applyStimulus(1'b0, 1'b0, 1'b0, 11'd0, 32'd0);
    repeat (3) tick();
    reset  = 1'b0;
    mon_en = 1'b1;
    tick();
    $display("[TB] reset state");
    checkOutput("rst_state", dut.state, IDLE);
    checkOutput("rst_busy", bus.busy, 1'b0);
    checkOutput("rst_done", bus.done, 1'b0);
    checkOutput("rst_we_re", {we, re}, 2'b00);
    checkOutput("rst_address", address, 11'd0);
    checkOutput("rst_rdata", bus.rdata, 32'd0);

    $display("[TB] word store / load");
    doTxn(1'b1, 1'b0, 11'h010, 32'hDEADBEEF, lat, rd);
    checkOutput("wst_latency", lat, 3);
    checkOutput("wst_mem_lo", mem[11'h010], 16'hBEEF);
    checkOutput("wst_mem_hi", mem[11'h011], 16'hDEAD);
    checkOutput("wst_rdata_kept", rd, 32'd0);
    doTxn(1'b0, 1'b0, 11'h010, 32'd0, lat, rd);
    checkOutput("wld_latency", lat, 3);
    checkOutput("wld_rdata", rd, 32'hDEADBEEF);

    $display("[TB] halfword store / load");
    doTxn(1'b1, 1'b1, 11'h021, 32'h00001234, lat, rd);
    checkOutput("hst_latency", lat, 2);
    checkOutput("hst_mem", mem[11'h021], 16'h1234);
    checkOutput("hst_neighbour", mem[11'h020], 16'h5A20);
    doTxn(1'b0, 1'b1, 11'h021, 32'd0, lat, rd);
    checkOutput("hld_latency", lat, 2);
    checkOutput("hld_rdata", rd, 32'h00001234);

    $display("[TB] halfword store ignores upper wdata");
    doTxn(1'b1, 1'b1, 11'h040, 32'hFFFFABCD, lat, rd);
    checkOutput("hst2_mem", mem[11'h040], 16'hABCD);
    checkOutput("hst2_neighbour", mem[11'h041], 16'h5A41);
    checkOutput("hst2_rdata_kept", rd, 32'h00001234);
    doTxn(1'b0, 1'b0, 11'h040, 32'd0, lat, rd);
    checkOutput("wld2_rdata", rd, 32'h5A41ABCD);
    doTxn(1'b0, 1'b1, 11'h035, 32'd0, lat, rd);
    checkOutput("hld2_rdata_zero_fill", rd, 32'h00005A35);

    $display("[TB] odd word address");
    applyStimulus(1'b1, 1'b0, 1'b0, 11'h011, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 11'h011, 32'd0);
    checkOutput("odd_addr_lo", address, 11'h010);
    checkOutput("odd_re_lo", re, 1'b1);
    tick();
    checkOutput("odd_addr_hi", address, 11'h011);
    tick();
    checkOutput("odd_done", bus.done, 1'b1);
    checkOutput("odd_rdata", bus.rdata, 32'hDEADBEEF);
    tick();

    $display("[TB] req held high");
    applyStimulus(1'b1, 1'b0, 1'b0, 11'h050, 32'd0);
    for (int i = 1; i <= 7; i++) begin
      tick();
      checkOutput("hold_done", bus.done, (i == 3 || i == 7));
      if (i == 3) checkOutput("hold_rdata_first", bus.rdata, 32'h5A515A50);
      if (i == 4) checkOutput("hold_idle_gap", bus.busy, 1'b0);
      if (i == 5) checkOutput("hold_second_addr", address, 11'h090);
      if (i == 7) checkOutput("hold_rdata_second", bus.rdata, 32'h5A915A90);
      applyStimulus(i < 7, 1'b0, 1'b0, 11'h050 + 11'(16 * i), 32'd0);
    end
    tick();
    checkOutput("hold_end_idle", bus.busy, 1'b0);

    $display("[TB] reset during word read");
    applyStimulus(1'b1, 1'b0, 1'b0, 11'h010, 32'd0);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 11'h010, 32'd0);
    checkOutput("rrd_re_before", re, 1'b1);
    reset = 1'b1;
    tick();
    checkOutput("rrd_state", dut.state, IDLE);
    checkOutput("rrd_we_re", {we, re}, 2'b00);
    checkOutput("rrd_address", address, 11'd0);
    checkOutput("rrd_rdata", bus.rdata, 32'd0);
    checkOutput("rrd_data_released", data, idle_pat);
    tick();
    reset = 1'b0;
    tick();
    checkOutput("rrd_busy_after", bus.busy, 1'b0);

    $display("[TB] reset during word write");
    applyStimulus(1'b1, 1'b1, 1'b0, 11'h100, 32'h11112222);
    tick();
    applyStimulus(1'b0, 1'b0, 1'b0, 11'h000, 32'd0);
    checkOutput("rwr_we_before", we, 1'b1);
    reset = 1'b1;
    tick();
    checkOutput("rwr_mem_lo", mem[11'h100], 16'h2222);
    checkOutput("rwr_mem_hi", mem[11'h101], 16'h5B01);
    checkOutput("rwr_we_after", we, 1'b0);
    reset = 1'b0;
    tick();

    $display("[TB] mixed random sequence");
    acc0  = accepted_cnt;
    done0 = done_cnt;
    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 2)) tick();
      rw = 1'($urandom_range(0, 1));
      rh = 1'($urandom_range(0, 1));
      doTxn(rw, rh, 11'($urandom_range(16'h200, 16'h2FF)), $urandom, lat, rd);
      checkOutput("rnd_latency", lat, rh ? 2 : 3);
    end
    repeat (3) tick();
    checkOutput("rnd_accepted", accepted_cnt - acc0, 24);
    checkOutput("rnd_done_once", done_cnt - done0, accepted_cnt - acc0);

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/sram_ctrl.md
# sram_ctrl

Initiator for the shared 16-bit SRAM bus. It converts single-cycle load/store requests from the CPU pipeline into one or two SRAM bus cycles. A 32-bit word takes two halfword accesses; a halfword takes one. It owns the address, we and re lines and drives the bidirectional data bus only while writing. It sits between the pipeline's memory stage and the SRAM.

## Interface
- ADDR_W, 11: SRAM address width, in halfwords.
- DATA_W, 16: SRAM data width. The CPU word is 2*DATA_W bits.
- clk  in  1  rising-edge clock, shared with the SRAM.
- reset  in  1  synchronous, active-high reset.
- req  in  1  request strobe. Sampled only in IDLE.
- wr  in  1  1 = store, 0 = load.
- half  in  1  1 = halfword access, 0 = word access.
- cpu_addr  in  ADDR_W  halfword address. Bit 0 is forced to 0 for word accesses.
- wdata  in  2*DATA_W  store data. Only the low DATA_W bits are used when half=1.
- rdata  out  2*DATA_W  load result. Upper half is zero-filled when half=1.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the transaction completes.
- address  out  ADDR_W  SRAM address.
- data  inout  DATA_W  SRAM data bus. High-impedance unless we=1.
- we  out  1  SRAM write enable.
- re  out  1  SRAM read enable.

## Operation
- States: IDLE, RD_LO, RD_HI, WR_LO, WR_HI, DONE. Moore FSM; we, re, address and the data drive are decoded from registered state only.
- Acceptance (IDLE):
  - req=1 at a rising edge latches wr, half, cpu_addr and wdata.
  - Next state: RD_LO if wr=0, WR_LO if wr=1.
  - req is ignored in every other state. No queueing.
- RD_LO: address={a[ADDR_W-1:1],~half&0|a[0]&half}, meaning even address for a word, the exact address for a halfword. re=1, we=0.
  - At the closing edge, data is captured into rdata[DATA_W-1:0].
  - Next state: RD_HI if word, DONE if half (upper rdata cleared to 0).
- RD_HI: address = low address + 1, re=1.
  - At the closing edge, data is captured into rdata[2*DATA_W-1:DATA_W].
  - Next state: DONE.
- WR_LO: address as in RD_LO. we=1, re=0, data driven with latched wdata[DATA_W-1:0]. The SRAM commits at the closing edge.
  - Next state: WR_HI if word, DONE if half.
- WR_HI: address = low address + 1, we=1, data driven with wdata[2*DATA_W-1:DATA_W].
  - Next state: DONE.
- DONE: done=1, busy=1, rdata stable. Next state: IDLE.
- Bus rules:
  - re and we are never both 1.
  - data is 'z whenever we=0.
  - address holds 0 in IDLE and DONE.
- Word order: low half at the even address, high half at odd.
- The +1 address never wraps, because the word base is even.
- rdata holds its last value until the next load captures. Stores do not alter it.

## Timing
- Reset values: state IDLE, rdata=0, done=0, busy=0, we=0, re=0, address=0, data='z.
- Reset has priority over every transition.
- Reset during an SRAM write cycle:
  - we is still 1 at the reset edge, so that halfword commits.
  - A word store interrupted after WR_LO leaves only the low half written. This is accepted behaviour.
- Word load/store: acceptance edge E0. The access states occupy the cycles after E0 and E1. done=1 in the cycle after E2. IDLE returns after E3, so a new req can be accepted at E4.
- Halfword: done=1 in the cycle after E1. A new req can be accepted at E3.
- busy rises the cycle after acceptance and falls with the return to IDLE.
- Reads rely on SRAM combinational read data settling within the cycle.

## Structure
- Package sram_ctrl_pkg holds:
  - state enum sram_ctrl_state_t, 3-bit encoding;
  - localparams SRAM_ADDR_W=11 and SRAM_DATA_W=16, shared with the SRAM instantiation.
- No sub-module. The tri-state driver is a single continuous assign gated by we.

## Test plan
- Reset check: hold reset 2 cycles in the middle of a word read. Required: state IDLE; we=re=0; address=0; rdata=0; data='z.
- Word store + load: wr=1, half=0, cpu_addr=0x010, wdata=0xDEADBEEF.
  - Required: mem[0x010]=0xBEEF and mem[0x011]=0xDEAD; done 3 cycles after acceptance.
  - Then load 0x010. Required: rdata=0xDEADBEEF when done=1.
- Halfword ops:
  - Store 0x1234 to 0x021. Required: mem[0x021]=0x1234, mem[0x020] unchanged; done 2 cycles after acceptance.
  - Load 0x021. Required: rdata=0x00001234.
- Odd word address: word load with cpu_addr=0x011. Required: accesses 0x010 then 0x011.
- Ignored req: hold req=1 continuously with varying addresses.
  - Required: only the address sampled in IDLE is used.
  - Required: busy blocks acceptance; next acceptance 4 cycles after the previous one for words.
- Bus contention check, every cycle of a mixed random sequence:
  - never re&we;
  - data='z whenever we=0;
  - done exactly once per accepted req.
